// File: rtl/click_decoder.sv
// click_decoder: groups debounced press pulses into single/double/triple click events.
//
// A group opens on the first pulse and stays open while pulses keep arriving within
// WINDOW cycles of each other. It closes, and its click count is pushed into a small
// event FIFO, when WINDOW cycles pass with no pulse or when MAX_CLICKS is reached.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, clears all state
//   in_pulse   debounced press pulse, one cycle wide
//   evt_valid  FIFO head is valid
//   evt_code   head event: 1=single, 2=double, 3=triple (0 when empty)
//   evt_ready  consumer accepts the head when evt_valid && evt_ready
//   evt_level  FIFO occupancy, 0..DEPTH
//   overflow   sticky: an event was dropped because the FIFO was full
module click_decoder #(
  parameter int unsigned WINDOW     = 25_000_000,
  parameter int unsigned TW         = 25,
  parameter int unsigned MAX_CLICKS = 3,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_pulse,
  output logic                     evt_valid,
  output logic [1:0]               evt_code,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [TW-1:0] TimeoutVal = TW'(WINDOW - 1);
  localparam logic [1:0]    MaxCode    = 2'(MAX_CLICKS);
  localparam logic [LW-1:0] FullLevel  = LW'(DEPTH);

  typedef enum logic {StIdle, StCount} state_e;

  state_e        state_q, state_d;
  logic [1:0]    clicks_q, clicks_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push;
  logic [1:0]    push_code;

  // Group-forming FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      clicks_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      clicks_q <= clicks_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clicks_d  = clicks_q;
    timer_d   = timer_q;
    push      = 1'b0;
    push_code = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (in_pulse) begin
          if (MAX_CLICKS == 1) begin
            push      = 1'b1;
            push_code = 2'd1;
          end else begin
            state_d  = StCount;
            clicks_d = 2'd1;
            timer_d  = '0;
          end
        end
      end
      StCount: begin
        // A pulse on the timeout cycle wins: it is counted and the window restarts.
        if (in_pulse) begin
          clicks_d = clicks_q + 2'd1;
          timer_d  = '0;
          if (clicks_d == MaxCode) begin
            push      = 1'b1;
            push_code = clicks_d;
            state_d   = StIdle;
            clicks_d  = 2'd0;
          end
        end else if (timer_q == TimeoutVal) begin
          push      = 1'b1;
          push_code = clicks_q;
          state_d   = StIdle;
          clicks_d  = 2'd0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Event FIFO
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic          full, pop, do_push, drop;

  assign full    = (level_q == FullLevel);
  assign pop     = evt_valid && evt_ready;
  // A simultaneous pop frees the slot, so push is legal even when full.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_code;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign evt_valid = (level_q != '0);
  assign evt_code  = evt_valid ? mem_q[rd_ptr_q] : 2'd0;
  assign evt_level = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_click_decoder.sv
module tb_click_decoder;

  localparam int unsigned WINDOW = 16;
  localparam int unsigned TW     = 5;
  localparam int unsigned MAXC   = 3;
  localparam int unsigned DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_pulse = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [2:0] evt_level;
  logic       overflow;

  click_decoder #(
    .WINDOW(WINDOW), .TW(TW), .MAX_CLICKS(MAXC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_pulse(in_pulse),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_level(evt_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int code;
    int at;   // expected cycle of acceptance, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted event must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none",
                 evt_code, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_code", int'(evt_code), e.code);
        if (e.at >= 0) check("evt_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    in_pulse = 1'b1;
    idle(1);
    in_pulse = 1'b0;
  endtask

  task automatic expect_evt(input int code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  int c0;

  initial begin
    // 1. reset state
    idle(3);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_code", int'(evt_code), 0);
    check("rst_level", int'(evt_level), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    idle(2);

    // 2. single click
    c0 = cyc;
    expect_evt(1, c0 + 17);
    pulse();
    drain("t2_drain", 40);
    check("t2_level", int'(evt_level), 0);
    idle(5);

    // 3. double click: pulses at 0 and 10
    c0 = cyc;
    expect_evt(2, c0 + 27);
    pulse();
    idle(9);
    pulse();
    drain("t3_drain", 40);
    idle(5);

    // 4. pulses exactly on the timeout cycle: closes on MAX_CLICKS path
    c0 = cyc;
    expect_evt(3, c0 + 33);
    pulse();
    idle(15);
    pulse();
    idle(15);
    pulse();
    drain("t4_drain", 20);
    idle(5);

    // 5. overflow: five singles while consumer stalls
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse();
      idle(39);
    end
    check("t5_level_full", int'(evt_level), 4);
    check("t5_overflow", int'(overflow), 1);
    check("t5_code_head", int'(evt_code), 1);
    for (int i = 0; i < 4; i++) expect_evt(1, -1);
    evt_ready = 1'b1;
    drain("t5_drain", 20);
    check("t5_level_empty", int'(evt_level), 0);
    check("t5_overflow_sticky", int'(overflow), 1);
    idle(5);

    // 6. reset mid-group discards it
    c0 = cyc;
    pulse();
    idle(4);
    pulse();
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t6_overflow_cleared", int'(overflow), 0);
    idle(11);
    expect_evt(1, c0 + 37);
    pulse();
    drain("t6_drain", 40);
    idle(20);
    check("t6_level", int'(evt_level), 0);
    check("t6_valid", int'(evt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
